// File: rtl/cmd_scheduler_if.sv
// Engine and PSL command/response bundle for cmd_scheduler.
// master = scheduler side, slave = engines/PSL side.
interface cmd_scheduler_if #(parameter int NREQ = 2);
    logic                 enable;
    logic [7:0]           ha_croom;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*13-1:0]   req_com;
    logic [NREQ*64-1:0]   req_ea;
    logic [NREQ*12-1:0]   req_size;
    logic [NREQ-1:0]      req_grant;
    logic [7:0]           grant_tag;
    logic                 ah_cvalid;
    logic [7:0]           ah_ctag;
    logic                 ah_ctagpar;
    logic [12:0]          ah_com;
    logic                 ah_compar;
    logic [2:0]           ah_cabt;
    logic [63:0]          ah_cea;
    logic                 ah_ceapar;
    logic [15:0]          ah_cch;
    logic [11:0]          ah_csize;
    logic                 ha_rvalid;
    logic [7:0]           ha_rtag;
    logic [7:0]           ha_response;
    logic [NREQ-1:0]      rsp_valid;
    logic [7:0]           rsp_tag;
    logic [7:0]           rsp_code;
    logic                 err_tag;
    logic                 idle;

    modport master (
        input  enable, ha_croom, req_valid, req_com, req_ea, req_size,
        input  ha_rvalid, ha_rtag, ha_response,
        output req_grant, grant_tag,
        output ah_cvalid, ah_ctag, ah_ctagpar, ah_com, ah_compar,
        output ah_cabt, ah_cea, ah_ceapar, ah_cch, ah_csize,
        output rsp_valid, rsp_tag, rsp_code, err_tag, idle
    );

    modport slave (
        output enable, ha_croom, req_valid, req_com, req_ea, req_size,
        output ha_rvalid, ha_rtag, ha_response,
        input  req_grant, grant_tag,
        input  ah_cvalid, ah_ctag, ah_ctagpar, ah_com, ah_compar,
        input  ah_cabt, ah_cea, ah_ceapar, ah_cch, ah_csize,
        input  rsp_valid, rsp_tag, rsp_code, err_tag, idle
    );
endinterface

// File: rtl/cmd_scheduler.sv
// Round-robin sharing of the PSL command port between NREQ engines,
// with credit tracking, tag allocation and response routing.
module cmd_scheduler #(
    parameter int NREQ = 2,
    parameter int TAGS = 32
) (
    input logic              ha_pclock,
    input logic              reset_n,
    cmd_scheduler_if.master  bus
);
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TAGS > 1) ? $clog2(TAGS) : 1;
    localparam logic [8:0] TAGS9 = 9'(TAGS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [8:0]      credits, credits_nxt;
    logic [8:0]      cmax, cmax_nxt;
    logic [8:0]      outst, outst_nxt;
    logic [TAGS-1:0] busy;
    logic [RW-1:0]   owner [TAGS];
    logic [RW-1:0]   rr, win;
    logic [7:0]      free_tag;
    logic            free_any, req_any, grant;
    logic            in_range, rsp_ok;
    logic [TW-1:0]   rtag_idx;

    always_comb begin
        free_any = 1'b0;
        free_tag = '0;
        for (int t = TAGS - 1; t >= 0; t--) begin
            if (!busy[t]) begin
                free_any = 1'b1;
                free_tag = 8'(t);
            end
        end
    end

    // Scan downward so the closest engine at/after rr wins.
    always_comb begin
        req_any = 1'b0;
        win     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(rr) + k) % NREQ]) begin
                req_any = 1'b1;
                win     = RW'((int'(rr) + k) % NREQ);
            end
        end
    end

    assign grant = (state == RUN) && bus.enable && (credits != 9'd0)
                   && free_any && req_any;

    assign bus.req_grant = grant ? (NREQ'(1) << win) : '0;
    assign bus.grant_tag = grant ? free_tag : 8'd0;

    assign in_range = ({1'b0, bus.ha_rtag} < TAGS9);
    assign rtag_idx = bus.ha_rtag[TW-1:0];
    assign rsp_ok   = bus.ha_rvalid && in_range && busy[rtag_idx];

    always_comb begin
        state_nxt   = state;
        cmax_nxt    = cmax;
        credits_nxt = credits + 9'(rsp_ok) - 9'(grant);
        outst_nxt   = outst + 9'(grant) - 9'(rsp_ok);
        if (credits_nxt > cmax) begin
            credits_nxt = cmax;
        end
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_nxt   = RUN;
                    cmax_nxt    = ({1'b0, bus.ha_croom} > TAGS9)
                                  ? TAGS9 : {1'b0, bus.ha_croom};
                    credits_nxt = cmax_nxt;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (outst == 9'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ha_pclock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            credits <= '0;
            cmax    <= '0;
            outst   <= '0;
            busy    <= '0;
            rr      <= '0;
            for (int t = 0; t < TAGS; t++) begin
                owner[t] <= '0;
            end
        end else begin
            state   <= state_nxt;
            credits <= credits_nxt;
            cmax    <= cmax_nxt;
            outst   <= outst_nxt;
            if (rsp_ok) begin
                busy[rtag_idx] <= 1'b0;
            end
            if (grant) begin
                busy[free_tag[TW-1:0]]  <= 1'b1;
                owner[free_tag[TW-1:0]] <= win;
                rr <= (win == RW'(NREQ - 1)) ? '0 : win + RW'(1);
            end
        end
    end

    always_ff @(posedge ha_pclock or negedge reset_n) begin
        if (!reset_n) begin
            bus.ah_cvalid  <= 1'b0;
            bus.ah_ctag    <= '0;
            bus.ah_ctagpar <= 1'b0;
            bus.ah_com     <= '0;
            bus.ah_compar  <= 1'b0;
            bus.ah_cea     <= '0;
            bus.ah_ceapar  <= 1'b0;
            bus.ah_csize   <= '0;
        end else begin
            bus.ah_cvalid <= grant;
            if (grant) begin
                bus.ah_ctag    <= free_tag;
                bus.ah_ctagpar <= ~^free_tag;
                bus.ah_com     <= bus.req_com[(NREQ-1-int'(win))*13 +: 13];
                bus.ah_compar  <= ~^bus.req_com[(NREQ-1-int'(win))*13 +: 13];
                bus.ah_cea     <= bus.req_ea[(NREQ-1-int'(win))*64 +: 64];
                bus.ah_ceapar  <= ~^bus.req_ea[(NREQ-1-int'(win))*64 +: 64];
                bus.ah_csize   <= bus.req_size[(NREQ-1-int'(win))*12 +: 12];
            end
        end
    end

    always_ff @(posedge ha_pclock or negedge reset_n) begin
        if (!reset_n) begin
            bus.rsp_valid <= '0;
            bus.rsp_tag   <= '0;
            bus.rsp_code  <= '0;
            bus.err_tag   <= 1'b0;
        end else begin
            bus.rsp_valid <= rsp_ok ? (NREQ'(1) << owner[rtag_idx]) : '0;
            bus.err_tag   <= bus.ha_rvalid && !rsp_ok;
            if (rsp_ok) begin
                bus.rsp_tag  <= bus.ha_rtag;
                bus.rsp_code <= bus.ha_response;
            end
        end
    end

    assign bus.ah_cabt = 3'd0;
    assign bus.ah_cch  = 16'd0;
    assign bus.idle    = (state == IDLE) && (outst == 9'd0);
endmodule
